// File: rtl/dff_write_arbiter.sv
// ============================================================================
// Module      : dff_write_arbiter
// Description : Round-robin write arbiter in front of a shared d_ff register
//               bank, with a four-phase handshake back to the winning requester.
//               Optional readback check: DFF_WRITE_ARB_READBACK_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  en,
    input  logic [WIDTH-1:0]      o,
    output logic                  done,
    output logic                  busy,
    output logic                  err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            r_state, w_state_next;
    logic [IDXW-1:0]   r_ptr, w_ptr_next;
    logic [IDXW-1:0]   r_winner, w_winner_next;
    logic [NREQ-1:0]   r_gnt, w_gnt_next;
    logic [WIDTH-1:0]  r_q, w_q_next;
    logic              r_en, w_en_next;
    logic              r_done, w_done_next;
    logic              r_busy, w_busy_next;

    logic [WIDTH-1:0]  w_words [NREQ];
    logic              w_found;
    logic [IDXW-1:0]   w_pick;
    logic [IDXW-1:0]   w_scan;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign w_words[g] = wdata[g*WIDTH +: WIDTH];
    end

    // First requester at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_scan = IDXW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_winner_next = r_winner;
        w_gnt_next    = r_gnt;
        w_q_next      = r_q;
        w_en_next     = 1'b0;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_winner_next = w_pick;
                    w_gnt_next    = NREQ'(1) << w_pick;
                    w_state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                // A requester that lets go before the write is dropped without
                // advancing the pointer, so it keeps its turn.
                if (!req[r_winner]) begin
                    w_gnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_q_next     = w_words[r_winner];
                    w_en_next    = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_done_next  = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_ptr_next   = (r_winner == IDXW'(NREQ-1)) ? '0 : r_winner + 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!req[r_winner]) begin
                    w_gnt_next   = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_gnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_gnt    <= '0;
            r_q      <= '0;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_winner <= w_winner_next;
            r_gnt    <= w_gnt_next;
            r_q      <= w_q_next;
            r_en     <= w_en_next;
            r_done   <= w_done_next;
            r_busy   <= w_busy_next;
        end
    end

    assign gnt  = r_gnt;
    assign q    = r_q;
    assign en   = r_en;
    assign done = r_done;
    assign busy = r_busy;

`ifdef DFF_WRITE_ARB_READBACK_CHECK_EN
    logic r_err, w_err_next;

    // Bank output reflects the write one cycle after the enable edge, i.e. in DONE.
    always_comb begin
        w_err_next = r_err;
        if (r_state == S_DONE && o != r_q) begin
            w_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign err = r_err;
`else
    logic w_unused_o;
    assign w_unused_o = ^o;
    assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
// ============================================================================
// Module      : tb_dff_write_arbiter
// Description : Directed self-checking bench for dff_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

`ifdef DFF_WRITE_ARB_READBACK_CHECK_EN
    localparam logic c_err_on_bad = 1'b1;
`else
    localparam logic c_err_on_bad = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  en;
    logic [WIDTH-1:0]      o;
    logic                  done;
    logic                  busy;
    logic                  err;

    logic [WIDTH-1:0]      bank = '0;
    logic [WIDTH-1:0]      corrupt = '0;

    int total = 0;
    int bad   = 0;

    dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .en      (en),
        .o       (o),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Register bank model; corrupt injects readback errors.
    always @(posedge clk) if (en) bank <= q;
    assign o = bank ^ corrupt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Full transaction from IDLE: requests already set; winner drops its req in WAIT.
    task automatic run_txn(input int w, input logic [7:0] d);
        step();
        chk("gnt_load", gnt, 32'(1) << w);
        chk("busy_load", busy, 1);
        chk("en_load", en, 0);
        step();
        chk("en_write", en, 1);
        chk("q_write", q, d);
        chk("done_write", done, 0);
        step();
        chk("done_done", done, 1);
        chk("en_done", en, 0);
        step();
        chk("done_wait", done, 0);
        chk("gnt_wait", gnt, 32'(1) << w);
        req[w] = 1'b0;
        step();
        chk("gnt_idle", gnt, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_q", q, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        do_reset();

        // Single request
        req = 4'b0001;
        run_txn(0, 8'hA5);

        // Contention and rotation 0,1,2,3,0
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        req = 4'b1111;
        run_txn(0, 8'h11); req[0] = 1'b1;
        run_txn(1, 8'h22); req[1] = 1'b1;
        run_txn(2, 8'h33); req[2] = 1'b1;
        run_txn(3, 8'h44); req[3] = 1'b1;
        run_txn(0, 8'h11);
        req = '0;

        // Wrap: serve 2 so ptr=3, then 3 beats 0
        do_reset();
        req = 4'b0100;
        run_txn(2, 8'h33);
        req = 4'b1001;
        run_txn(3, 8'h44);
        run_txn(0, 8'h11);
        req = '0;

        // Abort in LOAD (ptr=1)
        req = 4'b0010;
        step();
        chk("abort_gnt_load", gnt, 4'b0010);
        req = '0;
        step();
        chk("abort_gnt", gnt, 0);
        chk("abort_en", en, 0);
        chk("abort_busy", busy, 0);
        step();
        chk("abort_en2", en, 0);
        chk("abort_done", done, 0);
        req = 4'b1010;
        run_txn(1, 8'h22);
        req = '0;

        // Reset during WRITE (ptr=2)
        req = 4'b0100;
        step();
        chk("rw_gnt", gnt, 4'b0100);
        step();
        chk("rw_en", en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_en_async", en, 0);
        chk("rw_gnt_async", gnt, 0);
        chk("rw_q_async", q, 0);
        chk("rw_busy_async", busy, 0);
        step();
        chk("rw_en_held", en, 0);
        chk("rw_bank", bank, 8'h22);
        reset_n = 1'b1;
        req = 4'b0010;
        run_txn(1, 8'h22);
        req = '0;

        // Readback mismatch, then a good write
        corrupt = 8'h01;
        req = 4'b0001;
        run_txn(0, 8'h11);
        chk("err_set", err, c_err_on_bad);
        corrupt = 8'h00;
        req = 4'b0001;
        run_txn(0, 8'h11);
        chk("err_sticky", err, c_err_on_bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
